// File: rtl/cpu_bus_arbiter.sv
// N-port arbiter merging CPU-side masters onto one downstream memory bus.
// One transaction at a time; fixed-priority or round-robin, optional registered stage.
module cpu_bus_arbiter #(
    parameter int PORTS       = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 0,
    parameter int REGISTERED  = 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [PORTS-1:0]              i_request,
    input  logic [PORTS-1:0]              i_rw,
    input  logic [PORTS*ADDR_WIDTH-1:0]   i_address,
    input  logic [PORTS*DATA_WIDTH-1:0]   i_wdata,
    output logic [PORTS-1:0]              o_ready,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_bus_request,
    output logic                          o_bus_rw,
    output logic [ADDR_WIDTH-1:0]         o_bus_address,
    output logic [DATA_WIDTH-1:0]         o_bus_wdata,
    input  logic                          i_bus_ready,
    input  logic [DATA_WIDTH-1:0]         i_bus_rdata,
    output logic [PORTS-1:0]              o_grant,
    output logic                          o_busy,
    output logic [1:0]                    o_state
);

    localparam int IW = $clog2(PORTS);

    // Handshake: a port holds i_request until its one-cycle o_ready pulse;
    // downstream, o_bus_request stays high until the i_bus_ready pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [IW-1:0]           last_q, last_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [IW-1:0]           fx_idx, rr_idx, win_idx, rr_cand;
    logic [PORTS-1:0]        grant_oh;
    logic                    live_rw;
    logic [ADDR_WIDTH-1:0]   live_addr;
    logic [DATA_WIDTH-1:0]   live_wdata;

    // Descending scans so the last assignment is the highest-priority match.
    always_comb begin
        fx_idx  = '0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (i_request[p]) fx_idx = IW'(p);
        end
        for (int k = PORTS; k >= 1; k--) begin
            rr_cand = IW'((int'(last_q) + k) % PORTS);
            if (i_request[rr_cand]) rr_idx = rr_cand;
        end
        win_idx = (ROUND_ROBIN != 0) ? rr_idx : fx_idx;
    end

    assign grant_oh   = {{(PORTS-1){1'b0}}, 1'b1} << grant_q;
    assign live_rw    = i_rw[grant_q];
    assign live_addr  = i_address[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign live_wdata = i_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        o_ready       = '0;
        o_rdata       = '0;
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_grant       = '0;
        case (state_q)
            ST_IDLE: begin
                if (|i_request) begin
                    grant_d = win_idx;
                    last_d  = win_idx;
                    if (REGISTERED != 0) begin
                        rw_d    = i_rw[win_idx];
                        addr_d  = i_address[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_d = i_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_grant       = grant_oh;
                o_bus_request = 1'b1;
                o_bus_rw      = (REGISTERED != 0) ? rw_q    : live_rw;
                o_bus_address = (REGISTERED != 0) ? addr_q  : live_addr;
                o_bus_wdata   = (REGISTERED != 0) ? wdata_q : live_wdata;
                if (i_bus_ready) begin
                    if (REGISTERED != 0) begin
                        rdata_d = i_bus_rdata;
                        state_d = ST_DONE;
                    end else begin
                        o_ready = grant_oh;
                        o_rdata = i_bus_rdata;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                o_grant = grant_oh;
                o_ready = grant_oh;
                o_rdata = rdata_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(PORTS - 1);
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_state = state_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: four PORTS=4 instances covering fixed/round-robin x
// registered/combinational, directed scenarios, a vector table and a random run.
module tb_cpu_bus_arbiter;

    localparam int ND = 4;
    localparam int P  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    logic [P-1:0]    req       [ND];
    logic [P-1:0]    rw        [ND];
    logic [P*AW-1:0] addr      [ND];
    logic [P*DW-1:0] wdata     [ND];
    logic            bus_ready [ND];
    logic [DW-1:0]   bus_rdata [ND];

    logic [P-1:0]    ready_o   [ND];
    logic [DW-1:0]   rdata_o   [ND];
    logic            breq_o    [ND];
    logic            brw_o     [ND];
    logic [AW-1:0]   baddr_o   [ND];
    logic [DW-1:0]   bwdata_o  [ND];
    logic [P-1:0]    grant_o   [ND];
    logic            busy_o    [ND];
    logic [1:0]      state_o   [ND];

    int n_cmp;
    int n_fail;
    logic [P-1:0] exp_q[$];

    typedef struct {
        logic [P-1:0] req;
        logic [P-1:0] exp_fx;
        logic [P-1:0] exp_rr;
    } vec_t;
    vec_t tbl [10];

    // dut0 fixed/registered, dut1 rr/registered, dut2 fixed/comb, dut3 rr/comb
    for (genvar g = 0; g < ND; g++) begin : g_dut
        cpu_bus_arbiter #(
            .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .ROUND_ROBIN(g % 2), .REGISTERED((g < 2) ? 1 : 0)
        ) u_dut (
            .i_clock(clk),
            .i_reset(rst_n),
            .i_request(req[g]),
            .i_rw(rw[g]),
            .i_address(addr[g]),
            .i_wdata(wdata[g]),
            .o_ready(ready_o[g]),
            .o_rdata(rdata_o[g]),
            .o_bus_request(breq_o[g]),
            .o_bus_rw(brw_o[g]),
            .o_bus_address(baddr_o[g]),
            .o_bus_wdata(bwdata_o[g]),
            .i_bus_ready(bus_ready[g]),
            .i_bus_rdata(bus_rdata[g]),
            .o_grant(grant_o[g]),
            .o_busy(busy_o[g]),
            .o_state(state_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_reg(int d);
        return d < 2;
    endfunction

    function automatic bit is_rr(int d);
        return (d % 2) == 1;
    endfunction

    function automatic logic [127:0] outs(int d);
        return {ready_o[d], rdata_o[d], breq_o[d], brw_o[d], baddr_o[d],
                bwdata_o[d], grant_o[d], busy_o[d]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < ND; d++) begin
            req[d] = '0; rw[d] = '0; addr[d] = '0; wdata[d] = '0;
            bus_ready[d] = 1'b0; bus_rdata[d] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction from IDLE; returns in IDLE at a falling edge.
    task automatic table_txn(input int d, input logic [P-1:0] r, input logic [P-1:0] e);
        logic [DW-1:0] rd;
        int own;
        own = 0;
        for (int p = 0; p < P; p++) begin
            if (e[p]) own = p;
            addr[d][p*AW +: AW] = 32'hA000_0000 | (d << 8) | p;
        end
        req[d] = r;
        @(negedge clk); #1;
        check($sformatf("tbl_grant_d%0d", d), grant_o[d], e);
        check($sformatf("tbl_addr_d%0d", d), baddr_o[d], 32'hA000_0000 | (d << 8) | own);
        req[d] = '0;
        rd = $urandom;
        bus_ready[d] = 1'b1;
        bus_rdata[d] = rd;
        #1;
        if (!is_reg(d)) check($sformatf("tbl_ready_d%0d", d), {ready_o[d], rdata_o[d]}, {e, rd});
        @(negedge clk);
        bus_ready[d] = 1'b0;
        bus_rdata[d] = '0;
        #1;
        if (is_reg(d)) begin
            check($sformatf("tbl_ready_d%0d", d), {ready_o[d], rdata_o[d]}, {e, rd});
            @(negedge clk);
        end
    endtask

    task automatic run_random(input int cycles);
        bit            m_busy [ND];
        bit            m_done [ND];
        int            m_own  [ND];
        int            m_last [ND];
        logic          m_rw   [ND];
        logic [AW-1:0] m_addr [ND];
        logic [DW-1:0] m_wd   [ND];
        logic [DW-1:0] m_rd   [ND];
        logic [P-1:0]  e_ready, e_gr;
        logic [DW-1:0] e_rd, e_bw;
        logic [AW-1:0] e_ba;
        logic          e_breq, e_brw, e_busy;
        int            win, c;
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 0; m_done[d] = 0; m_own[d] = 0; m_last[d] = P - 1;
            m_rw[d] = 0; m_addr[d] = '0; m_wd[d] = '0; m_rd[d] = '0;
        end
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                req[d]       = ($urandom_range(0, 2) == 0) ? '0 : P'($urandom_range(1, 15));
                rw[d]        = P'($urandom_range(0, 15));
                for (int p = 0; p < P; p++) begin
                    addr[d][p*AW +: AW]  = $urandom;
                    wdata[d][p*DW +: DW] = $urandom;
                end
                bus_ready[d] = ($urandom_range(0, 2) == 0);
                bus_rdata[d] = $urandom;
            end
            #1;
            for (int d = 0; d < ND; d++) begin
                e_ready = '0; e_rd = '0; e_breq = 0; e_brw = 0;
                e_ba = '0; e_bw = '0; e_gr = '0; e_busy = 0;
                if (m_busy[d]) begin
                    e_busy = 1;
                    e_gr   = 4'b0001 << m_own[d];
                    if (m_done[d]) begin
                        e_ready = e_gr;
                        e_rd    = m_rd[d];
                    end else begin
                        e_breq = 1;
                        if (is_reg(d)) begin
                            e_brw = m_rw[d]; e_ba = m_addr[d]; e_bw = m_wd[d];
                        end else begin
                            e_brw = rw[d][m_own[d]];
                            e_ba  = addr[d][m_own[d]*AW +: AW];
                            e_bw  = wdata[d][m_own[d]*DW +: DW];
                            if (bus_ready[d]) begin
                                e_ready = e_gr;
                                e_rd    = bus_rdata[d];
                            end
                        end
                    end
                end
                check($sformatf("rand_d%0d_t%0d", d, t), outs(d),
                      {e_ready, e_rd, e_breq, e_brw, e_ba, e_bw, e_gr, e_busy});
                if (!m_busy[d]) begin
                    if (req[d] != 0) begin
                        win = -1;
                        for (int k = 1; k <= P; k++) begin
                            c = is_rr(d) ? (m_last[d] + k) % P : k - 1;
                            if (win < 0 && req[d][c]) win = c;
                        end
                        m_last[d] = win; m_own[d] = win; m_busy[d] = 1;
                        m_rw[d]   = rw[d][win];
                        m_addr[d] = addr[d][win*AW +: AW];
                        m_wd[d]   = wdata[d][win*DW +: DW];
                    end
                end else if (m_done[d]) begin
                    m_busy[d] = 0; m_done[d] = 0;
                end else if (bus_ready[d]) begin
                    if (is_reg(d)) begin
                        m_done[d] = 1; m_rd[d] = bus_rdata[d];
                    end else begin
                        m_busy[d] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        int cnt0, cnt3;
        n_cmp = 0;
        n_fail = 0;
        tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0001, 4'b0010};
        tbl[2] = '{4'b1001, 4'b0001, 4'b1000};
        tbl[3] = '{4'b1001, 4'b0001, 4'b0001};
        tbl[4] = '{4'b0110, 4'b0010, 4'b0010};
        tbl[5] = '{4'b0011, 4'b0001, 4'b0001};
        tbl[6] = '{4'b1100, 4'b0100, 4'b0100};
        tbl[7] = '{4'b0100, 4'b0100, 4'b0100};
        tbl[8] = '{4'b1010, 4'b0010, 4'b1000};
        tbl[9] = '{4'b0010, 4'b0010, 4'b0010};

        rst_n = 1'b0;
        clear_inputs();
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("reset_outs_d%0d", d), {outs(d), state_o[d]}, '0);

        // Registered read with two wait cycles on port 1
        do_reset();
        req[0] = 4'b0010;
        addr[0][AW +: AW] = 32'h100;
        #1 check("s1_idle", busy_o[0], 1'b0);
        @(negedge clk); #1;
        check("s1_issue", {breq_o[0], brw_o[0], baddr_o[0], grant_o[0]}, {1'b1, 1'b0, 32'h100, 4'b0010});
        addr[0][AW +: AW] = 32'h999;
        @(negedge clk); #1;
        check("s1_latched_addr", {baddr_o[0], ready_o[0]}, {32'h100, 4'b0000});
        @(negedge clk);
        bus_ready[0] = 1'b1;
        bus_rdata[0] = 32'hDEAD_BEEF;
        #1 check("s1_no_early_ready", ready_o[0], 4'b0000);
        @(negedge clk);
        bus_ready[0] = 1'b0; bus_rdata[0] = '0; req[0] = '0;
        #1 check("s1_ready", {ready_o[0], rdata_o[0], breq_o[0]}, {4'b0010, 32'hDEAD_BEEF, 1'b0});
        @(negedge clk); #1;
        check("s1_back_idle", {grant_o[0], ready_o[0], busy_o[0]}, '0);

        // Round-robin, all held
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req[1] = 4'b1111;
        bus_ready[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            if (ready_o[1] != 0) begin
                if (exp_q.size() == 0) check("rr_extra_ready", ready_o[1], '0);
                else check("rr_order", ready_o[1], exp_q.pop_front());
            end
        end
        req[1] = '0; bus_ready[1] = 1'b0;
        check("rr_count", exp_q.size(), 0);

        // Fixed priority starves port 3
        cnt0 = 0; cnt3 = 0;
        req[0] = 4'b1001;
        bus_ready[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (ready_o[0][0]) cnt0++;
            if (ready_o[0][3]) cnt3++;
        end
        req[0] = '0; bus_ready[0] = 1'b0;
        check("fx_port0_count", cnt0, 4);
        check("fx_port3_starved", cnt3, 0);

        // Combinational write, zero-wait downstream
        req[2] = 4'b0001; rw[2] = 4'b0001;
        addr[2][0 +: AW] = 32'h20; wdata[2][0 +: DW] = 32'h55;
        @(negedge clk);
        bus_ready[2] = 1'b1;
        #1 check("wr_issue", {breq_o[2], brw_o[2], baddr_o[2], bwdata_o[2], ready_o[2]},
                 {1'b1, 1'b1, 32'h20, 32'h55, 4'b0001});
        @(negedge clk);
        bus_ready[2] = 1'b0; req[2] = '0;
        #1 check("wr_idle", {breq_o[2], ready_o[2], busy_o[2]}, '0);

        // Arbitration table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < ND; d++) table_txn(d, tbl[i].req, is_rr(d) ? tbl[i].exp_rr : tbl[i].exp_fx);
        end

        // Reset during ISSUE, then a stray downstream ready
        req[0] = 4'b0001; req[2] = 4'b0100;
        @(negedge clk); #1;
        check("rst_mid_busy", {busy_o[0], busy_o[2]}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("rst_mid_outs_d%0d", d), {outs(d), state_o[d]}, '0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus_ready[0] = 1'b1; bus_ready[2] = 1'b1;
        #1 check("stray_ready_same", {ready_o[0], ready_o[2], busy_o[0], busy_o[2]}, '0);
        @(negedge clk);
        bus_ready[0] = 1'b0; bus_ready[2] = 1'b0;
        #1 check("stray_ready_next", {ready_o[0], ready_o[2], state_o[0], state_o[2]}, '0);

        do_reset();
        run_random(2500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
